// File: rtl/rvx_test_bus_shim.sv
`timescale 1ns/1ps
// Data-bus shim for the unit-test harness: injects fixed or LFSR-random wait states
// ahead of the memory port and serves the tohost mailbox and the 64-bit timer locally.
module rvx_test_bus_shim #(
    parameter int unsigned WAIT_MODE      = 0,
    parameter int unsigned WAIT_CYCLES    = 0,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    parameter logic [31:0] TOHOST_ADDRESS = 32'h0000_1000,
    parameter logic [31:0] MTIME_ADDRESS  = 32'h0000_1008
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] s_address,
    output logic [31:0] s_rdata,
    input  logic        s_rrequest,
    output logic        s_rresponse,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrobe,
    input  logic        s_wrequest,
    output logic        s_wresponse,
    output logic [31:0] m_address,
    input  logic [31:0] m_rdata,
    output logic        m_rrequest,
    input  logic        m_rresponse,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrobe,
    output logic        m_wrequest,
    input  logic        m_wresponse,
    output logic [63:0] memory_mapped_timer,
    output logic [31:0] tohost_value,
    output logic        test_done,
    output logic        test_pass,
    output logic        protocol_error
);

    typedef enum logic [2:0] {IDLE, DELAY, ISSUE, WAIT_RESP, LOCAL} state_t;

    localparam logic [3:0]  WAIT_MAX         = 4'(WAIT_CYCLES);
    localparam logic [31:0] MTIME_HI_ADDRESS = MTIME_ADDRESS + 32'd4;

    state_t      state;
    state_t      state_next;
    logic [31:0] address_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrobe_q;
    logic        write_q;
    logic        local_q;
    logic        tohost_q;
    logic [3:0]  count;
    logic [31:0] local_rdata;
    logic [7:0]  lfsr;
    logic [63:0] timer;
    logic [3:0]  wait_n;
    logic [31:0] merged;
    logic        any_request;
    logic        hit_tohost;
    logic        hit_mtime_lo;
    logic        hit_mtime_hi;
    logic        hit_local;

    assign any_request  = s_rrequest | s_wrequest;
    assign hit_tohost   = s_address[31:2] == TOHOST_ADDRESS[31:2];
    assign hit_mtime_lo = s_address[31:2] == MTIME_ADDRESS[31:2];
    assign hit_mtime_hi = s_address[31:2] == MTIME_HI_ADDRESS[31:2];
    assign hit_local    = hit_tohost | hit_mtime_lo | hit_mtime_hi;

    assign m_address           = address_q;
    assign m_wdata             = wdata_q;
    assign m_wstrobe           = wstrobe_q;
    assign memory_mapped_timer = timer;

    always_comb begin
        wait_n = 4'd0;
        if (WAIT_MODE == 1) begin
            wait_n = WAIT_MAX;
        end else if (WAIT_MODE == 2) begin
            wait_n = (lfsr[3:0] < WAIT_MAX) ? lfsr[3:0] : WAIT_MAX;
        end
    end

    always_comb begin
        merged = tohost_value;
        for (int b = 0; b < 4; b++) begin
            if (wstrobe_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_comb begin
        state_next  = state;
        m_rrequest  = 1'b0;
        m_wrequest  = 1'b0;
        s_rresponse = 1'b0;
        s_wresponse = 1'b0;
        s_rdata     = '0;
        case (state)
            IDLE: begin
                if (any_request) begin
                    if (wait_n != 4'd0)  state_next = DELAY;
                    else if (hit_local)  state_next = LOCAL;
                    else                 state_next = ISSUE;
                end
            end
            DELAY: begin
                if (count == 4'd1) state_next = local_q ? LOCAL : ISSUE;
            end
            ISSUE: begin
                m_rrequest = ~write_q;
                m_wrequest = write_q;
                state_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                // Responses pass straight through so the memory latency is not stretched.
                s_rresponse = m_rresponse;
                s_wresponse = m_wresponse;
                if (m_rresponse) s_rdata = m_rdata;
                if (write_q ? m_wresponse : m_rresponse) state_next = IDLE;
            end
            LOCAL: begin
                s_rresponse = ~write_q;
                s_wresponse = write_q;
                if (!write_q) s_rdata = local_rdata;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            address_q      <= '0;
            wdata_q        <= '0;
            wstrobe_q      <= '0;
            write_q        <= 1'b0;
            local_q        <= 1'b0;
            tohost_q       <= 1'b0;
            count          <= '0;
            local_rdata    <= '0;
            lfsr           <= LFSR_SEED;
            timer          <= '0;
            tohost_value   <= '0;
            test_done      <= 1'b0;
            test_pass      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state <= state_next;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            timer <= timer + 64'd1;
            if (state == IDLE && any_request) begin
                address_q   <= s_address;
                wdata_q     <= s_wdata;
                wstrobe_q   <= s_wstrobe;
                write_q     <= s_wrequest;
                local_q     <= hit_local;
                tohost_q    <= hit_tohost;
                count       <= wait_n;
                local_rdata <= hit_tohost   ? tohost_value :
                               hit_mtime_lo ? timer[31:0]  : timer[63:32];
            end
            if (state == DELAY) count <= count - 4'd1;
            if ((any_request && state != IDLE) || (s_rrequest && s_wrequest)) begin
                protocol_error <= 1'b1;
            end
            // The mailbox freezes once a result has been reported.
            if (state == LOCAL && write_q && tohost_q && !test_done) begin
                tohost_value <= merged;
                if (merged != 32'd0) begin
                    test_done <= 1'b1;
                    test_pass <= (merged == 32'd1);
                end
            end
        end
    end

endmodule
